// File: rtl/key_sequence_capture.sv
// key_sequence_capture
// Captures up to eight debounced push-button presses and compares them against
// a target sequence. The result is pass, mismatch or timeout.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a level change
//   TIMEOUT_CYCLES   maximum cycles allowed between accepted presses
// Ports
//   CLOCK_50   in   sole clock, rising edge
//   reset      in   synchronous active-high reset
//   KEY[3:0]   in   raw buttons, active-low, asynchronous
//   start      in   one-cycle pulse arming a capture (ignored while busy/done)
//   expected   in   target sequence, entry k at bits [2k+1:2k]
//   length     in   entries to capture (0 -> 1, >8 -> 8), sampled on start
//   busy       out  capture in progress
//   done       out  one-cycle pulse when a capture ends
//   pass       out  last capture matched completely
//   timeout    out  last capture ended by timeout
//   count      out  presses accepted in current/last capture
//   key_valid  out  one-cycle pulse per accepted press
//   last_key   out  index of the most recent accepted press
module key_sequence_capture #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 150000000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [3:0]  KEY,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic [3:0]  length,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [3:0]  count,
    output logic        key_valid,
    output logic [1:0]  last_key
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ZERO = TO_W'(0);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2,
        FINISH       = 2'd3
    } state_t;

    // Input conditioning
    logic [3:0]      sync1_r;
    logic [3:0]      sync2_r;
    logic [3:0]      level_s;
    logic [3:0]      stable_r;
    logic [3:0]      press_r;
    logic [DB_W-1:0] db_cnt_r [4];

    // Control and result registers
    state_t          state_r;
    state_t          state_nxt;
    logic [15:0]     exp_r,       exp_nxt;
    logic [3:0]      len_r,       len_nxt;
    logic [TO_W-1:0] tcnt_r,      tcnt_nxt;
    logic [3:0]      count_r,     count_nxt;
    logic            pass_r,      pass_nxt;
    logic            timeout_r,   timeout_nxt;
    logic            key_valid_r, key_valid_nxt;
    logic [1:0]      last_key_r,  last_key_nxt;
    logic            done_r,      done_nxt;
    logic            busy_r,      busy_nxt;

    // Decode helpers
    logic            press_any_s;
    logic            press_multi_s;
    logic [1:0]      low_idx_s;
    logic [1:0]      entry_s;
    logic            match_s;
    logic [3:0]      count_inc_s;
    logic            tmo_hit_s;
    logic [3:0]      len_clamp_s;

    // Two-flop synchronizer; reset value is the released (high) raw level
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_r <= 4'hF;
            sync2_r <= 4'hF;
        end else begin
            sync1_r <= KEY;
            sync2_r <= sync1_r;
        end
    end

    assign level_s = ~sync2_r;

    // Per-key debouncer; press_r pulses in the cycle the stable level rises
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            stable_r <= 4'h0;
            press_r  <= 4'h0;
            for (int k = 0; k < 4; k++) begin
                db_cnt_r[k] <= DB_ZERO;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (level_s[k] == stable_r[k]) begin
                    // Agreement with the stable level breaks any pending run
                    db_cnt_r[k] <= DB_ZERO;
                    press_r[k]  <= 1'b0;
                end else if (db_cnt_r[k] == DB_LAST) begin
                    stable_r[k] <= level_s[k];
                    db_cnt_r[k] <= DB_ZERO;
                    press_r[k]  <= level_s[k];
                end else begin
                    db_cnt_r[k] <= db_cnt_r[k] + DB_ONE;
                    press_r[k]  <= 1'b0;
                end
            end
        end
    end

    // Lowest pressed index and comparison against the current sequence entry
    always_comb begin
        press_any_s   = (press_r != 4'h0);
        press_multi_s = ((press_r & (press_r - 4'd1)) != 4'h0);
        if (press_r[0]) begin
            low_idx_s = 2'd0;
        end else if (press_r[1]) begin
            low_idx_s = 2'd1;
        end else if (press_r[2]) begin
            low_idx_s = 2'd2;
        end else begin
            low_idx_s = 2'd3;
        end
        entry_s     = exp_r[{count_r[2:0], 1'b0} +: 2];
        match_s     = !press_multi_s && (low_idx_s == entry_s);
        count_inc_s = count_r + 4'd1;
        tmo_hit_s   = (tcnt_r == TO_LAST);
        if (length == 4'd0) begin
            len_clamp_s = 4'd1;
        end else if (length > 4'd8) begin
            len_clamp_s = 4'd8;
        end else begin
            len_clamp_s = length;
        end
    end

    // State and output register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r     <= IDLE;
            exp_r       <= 16'h0000;
            len_r       <= 4'd0;
            tcnt_r      <= TO_ZERO;
            count_r     <= 4'd0;
            pass_r      <= 1'b0;
            timeout_r   <= 1'b0;
            key_valid_r <= 1'b0;
            last_key_r  <= 2'd0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            exp_r       <= exp_nxt;
            len_r       <= len_nxt;
            tcnt_r      <= tcnt_nxt;
            count_r     <= count_nxt;
            pass_r      <= pass_nxt;
            timeout_r   <= timeout_nxt;
            key_valid_r <= key_valid_nxt;
            last_key_r  <= last_key_nxt;
            done_r      <= done_nxt;
            busy_r      <= busy_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt = WAIT_PRESS;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT_PRESS: begin
                if (press_any_s) begin
                    if (!match_s || (count_inc_s == len_r)) begin
                        state_nxt = FINISH;
                    end else begin
                        state_nxt = WAIT_RELEASE;
                    end
                end else if (tmo_hit_s) begin
                    state_nxt = FINISH;
                end else begin
                    state_nxt = WAIT_PRESS;
                end
            end
            WAIT_RELEASE: begin
                if (tmo_hit_s) begin
                    state_nxt = FINISH;
                end else if (stable_r == 4'h0) begin
                    state_nxt = WAIT_PRESS;
                end else begin
                    state_nxt = WAIT_RELEASE;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and output next values; done/busy follow the next state so
    // they line up with the state register
    always_comb begin
        exp_nxt       = exp_r;
        len_nxt       = len_r;
        tcnt_nxt      = tcnt_r;
        count_nxt     = count_r;
        pass_nxt      = pass_r;
        timeout_nxt   = timeout_r;
        key_valid_nxt = 1'b0;
        last_key_nxt  = last_key_r;
        done_nxt      = (state_nxt == FINISH);
        busy_nxt      = (state_nxt == WAIT_PRESS) || (state_nxt == WAIT_RELEASE);
        case (state_r)
            IDLE: begin
                if (start) begin
                    exp_nxt     = expected;
                    len_nxt     = len_clamp_s;
                    tcnt_nxt    = TO_ZERO;
                    count_nxt   = 4'd0;
                    pass_nxt    = 1'b0;
                    timeout_nxt = 1'b0;
                end else begin
                    exp_nxt = exp_r;
                end
            end
            WAIT_PRESS: begin
                if (press_any_s) begin
                    key_valid_nxt = 1'b1;
                    last_key_nxt  = low_idx_s;
                    count_nxt     = count_inc_s;
                    tcnt_nxt      = TO_ZERO;
                    pass_nxt      = match_s && (count_inc_s == len_r);
                end else if (tmo_hit_s) begin
                    timeout_nxt = 1'b1;
                end else begin
                    tcnt_nxt = tcnt_r + TO_ONE;
                end
            end
            WAIT_RELEASE: begin
                if (tmo_hit_s) begin
                    timeout_nxt = 1'b1;
                end else begin
                    tcnt_nxt = tcnt_r + TO_ONE;
                end
            end
            FINISH: begin
                tcnt_nxt = tcnt_r;
            end
            default: begin
                tcnt_nxt = TO_ZERO;
            end
        endcase
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign timeout   = timeout_r;
    assign count     = count_r;
    assign key_valid = key_valid_r;
    assign last_key  = last_key_r;

endmodule

// File: doc/key_sequence_capture.md
KEY_SEQUENCE_CAPTURE -- requirements
Module: key_sequence_capture

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable samples needed to accept a key level change (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 150000000, meaning maximum cycles allowed between accepted presses (3 s).
REQ-003 The block SHALL have port CLOCK_50  input  1  sole clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port KEY  input  4  raw push buttons, active-low (0 = pressed), asynchronous to CLOCK_50.
REQ-006 The block SHALL have port start  input  1  one-cycle pulse that arms a capture.
REQ-007 The block SHALL have port expected  input  16  target sequence: entry k is bits [2k+1:2k], a key index 0..3.
REQ-008 The block SHALL have port length  input  4  entries to capture, 1..8; sampled on start.
REQ-009 The block SHALL have port busy  output  1  high while a capture is in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse when a capture ends.
REQ-011 The block SHALL have port pass  output  1  result of the last capture, valid from done until the next start.
REQ-012 The block SHALL have port timeout  output  1  last capture ended by timeout; same validity as pass.
REQ-013 The block SHALL have port count  output  4  presses accepted in current/last capture.
REQ-014 The block SHALL have port key_valid  output  1  one-cycle pulse per accepted press.
REQ-015 The block SHALL have port last_key  output  2  index of the most recent accepted press.

Function
REQ-016 Each KEY bit SHALL pass through a two-flop synchronizer, then be inverted to an active-high level.
REQ-017 Each key SHALL have its own debouncer: its stable level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples differing from the current stable level; any differing sample restarts the count.
REQ-018 A press event SHALL be a stable-level 0->1 transition; releases generate no event.
REQ-019 The FSM SHALL have states IDLE, WAIT_PRESS, WAIT_RELEASE, FINISH.
REQ-020 IDLE: start -> latch expected and length, clear count, pass, timeout and the timeout counter, go to WAIT_PRESS; busy high from the next cycle.
REQ-021 WAIT_PRESS: exactly one press event -> pulse key_valid, update last_key, increment count, compare against entry count (pre-increment), go to WAIT_RELEASE.
REQ-022 A mismatching press SHALL go to FINISH with pass=0; a matching press whose new count equals length SHALL go to FINISH with pass=1.
REQ-023 Two or more press events in the same cycle SHALL count as one mismatch; count increments, last_key = lowest pressed index.
REQ-024 WAIT_RELEASE: when all four stable levels are 0, return to WAIT_PRESS; press events here are ignored.
REQ-025 The timeout counter SHALL run in WAIT_PRESS and WAIT_RELEASE, clear on every accepted press, and on reaching TIMEOUT_CYCLES-1 go to FINISH with pass=0, timeout=1.
REQ-026 FINISH: pulse done for one cycle, drop busy, return to IDLE; outputs hold.
REQ-027 start while busy SHALL be ignored; start in the done cycle SHALL be ignored.
REQ-028 length of 0 SHALL be treated as 1; values above 8 as 8.
REQ-029 A key held down when start arrives SHALL NOT produce a press; it must be released and pressed again.

Reset
REQ-030 reset SHALL force IDLE and clear busy, done, pass, timeout, count, key_valid, last_key, all debounce and timeout counters; stable levels = released.
REQ-031 reset SHALL dominate start and press events in the same cycle; reset mid-capture SHALL abort without a done pulse.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100)
REQ-032 expected=16'h00E4, length=4, clean presses 0,1,2,3 -> four key_valid pulses, done with pass=1, timeout=0, count=4.
REQ-033 Same setup, presses 0,2 -> done after second press, pass=0, count=2, last_key=2.
REQ-034 KEY[1] bounces 0/1 every 2 cycles for 20 cycles then held -> exactly one key_valid, last_key=1.
REQ-035 length=3, one correct press then idle 100 cycles -> done with pass=0, timeout=1, count=1.
REQ-036 KEY[0] and KEY[3] pressed in same cycle -> one key_valid, last_key=0, done with pass=0.
REQ-037 reset asserted in WAIT_RELEASE with count=2 -> next cycle busy=0, count=0, no done pulse.
